// File: rtl/axi_ni_response_depacketizer_pkg.sv
// Shared NI response definitions: flit type codes, response codes, header field offsets
// and the widths used by the response depacketizer and its header decoder.
package axi_ni_response_depacketizer_pkg;

   localparam int FTYPEWD          = 2;
   localparam int FLIT_WIDTH       = 32;
   localparam int BASE_WIDTH       = FLIT_WIDTH - FTYPEWD;
   localparam int AXIRDATAWD       = 32;
   localparam int FLITS_PER_BEAT   = (AXIRDATAWD + BASE_WIDTH - 1) / BASE_WIDTH;
   localparam int LENWD            = 8;
   localparam int FCNT_W           = $clog2(FLITS_PER_BEAT) + 1;
   localparam int PACKETTRANSIDWD  = 8;
   localparam int PACKETRESPONSEWD = 2;
   localparam int PACKETREADDATAWD = AXIRDATAWD;

   localparam int HDR_ID_LSB   = 0;
   localparam int HDR_RESP_LSB = HDR_ID_LSB + PACKETTRANSIDWD;
   localparam int HDR_READ_BIT = HDR_RESP_LSB + PACKETRESPONSEWD;
   localparam int HDR_LOCK_BIT = HDR_READ_BIT + 1;
   localparam int HDR_LEN_LSB  = HDR_LOCK_BIT + 1;

   localparam logic [PACKETRESPONSEWD-1:0] PACKETRESPDVA = 2'b01;
   localparam logic [PACKETRESPONSEWD-1:0] PACKETRESPERR = 2'b11;

   typedef enum logic [FTYPEWD-1:0] {
      FT_HEADER     = 2'b00,
      FT_PAYLOAD    = 2'b01,
      FT_TAIL       = 2'b10,
      FT_HEADERTAIL = 2'b11
   } ftype_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_DATA = 2'b01,
      ST_HOLD = 2'b10
   } state_e;

   typedef struct packed {
      logic [LENWD-1:0]            len;
      logic                        locked;
      logic                        is_read;
      logic [PACKETRESPONSEWD-1:0] resp;
      logic [PACKETTRANSIDWD-1:0]  id;
   } hdr_t;

endpackage

// File: rtl/axi_ni_response_depacketizer_if.sv
// Flit channel from the NI input buffer into the response depacketizer.
interface axi_ni_response_depacketizer_if;
   import axi_ni_response_depacketizer_pkg::*;

   logic [FLIT_WIDTH-1:0] flit_in;
   logic                  flit_in_valid;
   logic                  flit_in_ready;

   modport master (output flit_in, output flit_in_valid, input  flit_in_ready);
   modport slave  (input  flit_in, input  flit_in_valid, output flit_in_ready);

endinterface

// File: rtl/ni_flit_header_decoder.sv
// Combinational split of a response flit into type, payload and header fields.
module ni_flit_header_decoder
   import axi_ni_response_depacketizer_pkg::*;
(
   input  logic [FLIT_WIDTH-1:0] flit,
   output ftype_e                ftype,
   output logic [BASE_WIDTH-1:0] payload,
   output hdr_t                  hdr
);

   assign ftype   = ftype_e'(flit[FLIT_WIDTH-1 -: FTYPEWD]);
   assign payload = flit[BASE_WIDTH-1:0];

   assign hdr.id      = payload[HDR_ID_LSB +: PACKETTRANSIDWD];
   assign hdr.resp    = payload[HDR_RESP_LSB +: PACKETRESPONSEWD];
   assign hdr.is_read = payload[HDR_READ_BIT];
   assign hdr.locked  = payload[HDR_LOCK_BIT];
   assign hdr.len     = payload[HDR_LEN_LSB +: LENWD];

endmodule

// File: rtl/axi_ni_response_depacketizer.sv
// Initiator-NI receive stage: rebuilds AXI R/B response beats from NoC flits and holds
// each beat toward the pin mask until the master accepts it.
module axi_ni_response_depacketizer
   import axi_ni_response_depacketizer_pkg::*;
(
   input  logic                          clock,
   input  logic                          reset,
   axi_ni_response_depacketizer_if.slave flit_if,
   input  logic                          RREADY,
   input  logic                          BREADY,
   output logic                          mask_response,
   output logic [PACKETRESPONSEWD-1:0]   received_response,
   output logic [PACKETREADDATAWD-1:0]   received_data,
   output logic [PACKETTRANSIDWD-1:0]    received_id,
   output logic                          packet_type_is_read,
   output logic                          message_is_locked,
   output logic                          RLAST,
   output logic                          protocol_error
);

   ftype_e                      ftype_s;
   logic [BASE_WIDTH-1:0]       payload_s;
   hdr_t                        hdr_s;

   state_e                      state_r,    state_s;
   logic [LENWD-1:0]            beat_cnt_r, beat_cnt_s;
   logic [FCNT_W-1:0]           flit_cnt_r, flit_cnt_s;
   logic [LENWD-1:0]            len_r,      len_s;
   logic [PACKETTRANSIDWD-1:0]  id_r,       id_s;
   logic [PACKETRESPONSEWD-1:0] resp_r,     resp_s;
   logic                        is_read_r,  is_read_s;
   logic                        locked_r,   locked_s;
   logic [AXIRDATAWD-1:0]       data_r,     data_s;
   logic                        rlast_r,    rlast_s;
   logic                        perr_r,     perr_s;
   logic                        mask_r,     mask_s;
   logic                        ready_r,    ready_s;

   logic                        accept_s;
   logic                        pop_s;
   logic                        last_flit_s;
   logic                        last_beat_s;
   logic [AXIRDATAWD-1:0]       slice_s;

   ni_flit_header_decoder u_hdr_dec (
      .flit    (flit_if.flit_in),
      .ftype   (ftype_s),
      .payload (payload_s),
      .hdr     (hdr_s)
   );

   // Next-state and holding-register update for the receive FSM.
   always_comb begin
      state_s    = state_r;
      beat_cnt_s = beat_cnt_r;
      flit_cnt_s = flit_cnt_r;
      len_s      = len_r;
      id_s       = id_r;
      resp_s     = resp_r;
      is_read_s  = is_read_r;
      locked_s   = locked_r;
      data_s     = data_r;
      rlast_s    = rlast_r;
      perr_s     = perr_r;

      accept_s    = flit_if.flit_in_valid & ready_r;
      pop_s       = (is_read_r & RREADY) | (~is_read_r & BREADY);
      last_flit_s = (flit_cnt_r == FCNT_W'(FLITS_PER_BEAT - 1));
      last_beat_s = (beat_cnt_r == len_r);
      // Slices beyond the data width shift out and are dropped.
      slice_s     = data_r | (AXIRDATAWD'(payload_s) << (32'(flit_cnt_r) * BASE_WIDTH));

      case (state_r)
         ST_IDLE: begin
            if (accept_s && ftype_s == FT_HEADERTAIL && !hdr_s.is_read) begin
               id_s      = hdr_s.id;
               resp_s    = hdr_s.resp;
               is_read_s = 1'b0;
               locked_s  = hdr_s.locked;
               len_s     = hdr_s.len;
               data_s    = '0;
               rlast_s   = 1'b1;
               state_s   = ST_HOLD;
            end else if (accept_s && ftype_s == FT_HEADER && hdr_s.is_read) begin
               id_s       = hdr_s.id;
               resp_s     = hdr_s.resp;
               is_read_s  = 1'b1;
               locked_s   = hdr_s.locked;
               len_s      = hdr_s.len;
               data_s     = '0;
               rlast_s    = 1'b0;
               beat_cnt_s = '0;
               flit_cnt_s = '0;
               state_s    = ST_DATA;
            end else if (accept_s) begin
               perr_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (accept_s) begin
               case (ftype_s)
                  FT_PAYLOAD, FT_TAIL: begin
                     data_s = slice_s;
                     if (ftype_s == FT_TAIL && !(last_flit_s && last_beat_s)) begin
                        perr_s  = 1'b1;
                        resp_s  = PACKETRESPERR;
                        rlast_s = 1'b1;
                        state_s = ST_HOLD;
                     end else if (last_flit_s) begin
                        rlast_s = last_beat_s;
                        perr_s  = perr_r | (last_beat_s & (ftype_s == FT_PAYLOAD));
                        state_s = ST_HOLD;
                     end else begin
                        flit_cnt_s = flit_cnt_r + FCNT_W'(1);
                     end
                  end
                  default: perr_s = 1'b1;
               endcase
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_HOLD: begin
            if (pop_s && rlast_r) begin
               state_s = ST_IDLE;
            end else if (pop_s) begin
               beat_cnt_s = beat_cnt_r + LENWD'(1);
               flit_cnt_s = '0;
               data_s     = '0;
               state_s    = ST_DATA;
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: state_s = ST_IDLE;
      endcase

      // A held beat blocks the flit channel and unmasks the response pins.
      mask_s  = (state_s != ST_HOLD);
      ready_s = (state_s != ST_HOLD);
   end

   // State, counters and output holding registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         beat_cnt_r <= '0;
         flit_cnt_r <= '0;
         len_r      <= '0;
         id_r       <= '0;
         resp_r     <= '0;
         is_read_r  <= 1'b0;
         locked_r   <= 1'b0;
         data_r     <= '0;
         rlast_r    <= 1'b0;
         perr_r     <= 1'b0;
         mask_r     <= 1'b1;
         ready_r    <= 1'b1;
      end else begin
         state_r    <= state_s;
         beat_cnt_r <= beat_cnt_s;
         flit_cnt_r <= flit_cnt_s;
         len_r      <= len_s;
         id_r       <= id_s;
         resp_r     <= resp_s;
         is_read_r  <= is_read_s;
         locked_r   <= locked_s;
         data_r     <= data_s;
         rlast_r    <= rlast_s;
         perr_r     <= perr_s;
         mask_r     <= mask_s;
         ready_r    <= ready_s;
      end
   end

   assign flit_if.flit_in_ready = ready_r;
   assign mask_response         = mask_r;
   assign received_response     = resp_r;
   assign received_data         = data_r;
   assign received_id           = id_r;
   assign packet_type_is_read   = is_read_r;
   assign message_is_locked     = locked_r;
   assign RLAST                 = rlast_r;
   assign protocol_error        = perr_r;

endmodule
